led_sequencer: RTL and testbench

Parametrised multi-mode LED pattern generator driving a bank of `LED_NUM` board LEDs from the system clock. An internal prescaler produces a step event every `TICK_MAX >> speed_sel` cycles. On each step the pattern advances according to the selected mode: rotate, bounce, blink or bar fill. It replaces fixed 4-LED running-light logic in board top levels and adds runtime mode, direction and speed control.

---
 rtl/led_seq_pkg.sv | 11 +
 rtl/led_seq_tick.sv | 23 ++
 rtl/led_sequencer.sv | 100 ++++++++++
 tb/tb_led_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encodings and default constants for the LED sequencer.
package led_seq_pkg;
  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;
  localparam int TICK_MAX_DEF = 25_000_000;
  localparam int PWM_W = 4;
endpackage

// File: rtl/led_seq_tick.sv
// led_seq_tick: prescaler emitting a step strobe every TICK_MAX >> speed_sel clocks.
module led_seq_tick
  import led_seq_pkg::*;
#(
  parameter int TICK_MAX = 8,
  parameter int CNT_W = $clog2(TICK_MAX)
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] speed_sel,
  input  logic       clr,
  output logic       step
);
  localparam logic [31:0] TM = TICK_MAX;
  logic [CNT_W-1:0] cnt;
  logic [31:0] per_m1;
  assign per_m1 = (TM >> speed_sel) - 32'd1;
  // >= rather than == so a faster speed_sel never skips a step
  assign step = 32'(cnt) >= per_m1;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n || clr || step) cnt <= '0;
    else cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: multi-mode LED pattern generator (run, bounce, blink, fill).
// Define LED_SEQ_PWM_EN to add a duty input that dims the LEDs with a 4-bit PWM.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int LED_NUM = 4,
  parameter int TICK_MAX = TICK_MAX_DEF,
  parameter int CNT_W = $clog2(TICK_MAX)
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [1:0]         speed_sel,
`ifdef LED_SEQ_PWM_EN
  input  logic [PWM_W-1:0]   duty,
`endif
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse,
  output logic               wrap
);
  localparam logic [LED_NUM-1:0] LSB = 1;
  localparam logic [LED_NUM-1:0] MSB = LSB << (LED_NUM - 1);
  mode_t m, mode_q;
  logic init, bdn, nxt_bdn, nxt_wrap, load, step;
  logic [LED_NUM-1:0] pat, nxt, start, rev;
  assign m = mode_t'(mode);
  assign load = init || m != mode_q;
  for (genvar i = 0; i < LED_NUM; i++) begin : g_rev
    assign rev[i] = pat[LED_NUM-1-i];
  end
  led_seq_tick #(.TICK_MAX(TICK_MAX), .CNT_W(CNT_W)) u_tick (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .speed_sel(speed_sel),
    .clr(load),
    .step(step)
  );
  always_comb begin
    start = (m == MODE_RUN && dir) ? MSB :
            (m == MODE_RUN || m == MODE_BOUNCE) ? LSB :
            (m == MODE_BLINK) ? '1 : '0;
    nxt = pat;
    nxt_wrap = 1'b0;
    nxt_bdn = bdn;
    case (mode_q)
      MODE_RUN: begin
        nxt = dir ? {pat[0], pat[LED_NUM-1:1]} : {pat[LED_NUM-2:0], pat[LED_NUM-1]};
        nxt_wrap = nxt == (dir ? MSB : LSB);
      end
      MODE_BOUNCE: begin
        nxt = bdn ? pat >> 1 : pat << 1;
        nxt_bdn = bdn ? !nxt[0] : nxt[LED_NUM-1];
        nxt_wrap = nxt[0];
      end
      MODE_BLINK: begin
        nxt = ~pat;
        nxt_wrap = &nxt;
      end
      default: begin
        // a full bar, or a bar not contiguous from the current fill end, restarts at zero
        nxt = (&pat || (dir ? |(rev & (rev + LSB)) : |(pat & (pat + LSB)))) ? '0 :
              dir ? {1'b1, pat[LED_NUM-1:1]} : {pat[LED_NUM-2:0], 1'b1};
        nxt_wrap = nxt == '0;
      end
    endcase
  end
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      pat <= '0;
      step_pulse <= 1'b0;
      wrap <= 1'b0;
      mode_q <= MODE_RUN;
      init <= 1'b1;
      bdn <= 1'b0;
    end else if (load) begin
      pat <= start;
      step_pulse <= 1'b0;
      wrap <= 1'b0;
      mode_q <= m;
      init <= 1'b0;
      bdn <= 1'b0;
    end else begin
      step_pulse <= step;
      wrap <= step && nxt_wrap;
      if (step) begin
        pat <= nxt;
        bdn <= nxt_bdn;
      end
    end
`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + PWM_W'(1);
  assign led = pat & {LED_NUM{pwm_cnt < duty || &duty}};
`else
  assign led = pat;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed vectors plus an index-based reference model checked every cycle.
module tb_led_sequencer;
  localparam int N = 4;
  localparam int TM = 8;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic [1:0] mode = 2'd0;
  logic dir = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [N-1:0] led;
  logic step_pulse, wrap;
`ifdef LED_SEQ_PWM_EN
  logic [3:0] duty = 4'd15;
`endif
  int vectors = 0;
  int errors = 0;

  led_sequencer #(.LED_NUM(N), .TICK_MAX(TM)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .mode(mode),
    .dir(dir),
    .speed_sel(speed_sel),
`ifdef LED_SEQ_PWM_EN
    .duty(duty),
`endif
    .led(led),
    .step_pulse(step_pulse),
    .wrap(wrap)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // model: positions/levels/phases rather than bit patterns
  int m_cnt = 0, m_pos = 0, m_k = 0, m_blk = 0, m_lvl = 0, m_pwm = 0;
  logic m_init = 1'b1, m_fdir = 1'b0, m_step = 1'b0, m_wrap = 1'b0;
  logic [1:0] m_mq = 2'd0;
  logic chk_en = 1'b0;

  function automatic logic [N-1:0] m_pat();
    if (m_init) return '0;
    case (m_mq)
      2'd0: return N'(1 << m_pos);
      2'd1: return N'(1 << (m_k < N ? m_k : 2 * (N - 1) - m_k));
      2'd2: return m_blk != 0 ? '0 : '1;
      default: return m_fdir ? N'(((1 << m_lvl) - 1) << (N - m_lvl)) : N'((1 << m_lvl) - 1);
    endcase
  endfunction

  always @(negedge sys_clk) begin
    logic [N-1:0] e;
    if (chk_en) begin
      e = m_pat();
`ifdef LED_SEQ_PWM_EN
      if (!(m_pwm < int'(duty) || duty == 4'd15)) e = '0;
`endif
      chk("model led", 32'(led), 32'(e));
      chk("model step_pulse", 32'(step_pulse), 32'(m_step));
      chk("model wrap", 32'(wrap), 32'(m_wrap));
    end
    chk_en = 1'b1;
    if (!sys_rst_n) begin
      m_init = 1'b1; m_mq = 2'd0; m_cnt = 0; m_step = 1'b0; m_wrap = 1'b0; m_pwm = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 16;
      m_step = 1'b0;
      m_wrap = 1'b0;
      if (m_init || mode != m_mq) begin
        m_init = 1'b0; m_mq = mode; m_cnt = 0;
        m_pos = dir ? N - 1 : 0; m_k = 0; m_blk = 0; m_lvl = 0; m_fdir = dir;
      end else if (m_cnt >= (TM >> speed_sel) - 1) begin
        m_cnt = 0;
        m_step = 1'b1;
        case (m_mq)
          2'd0: begin
            m_pos = dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
            m_wrap = m_pos == (dir ? N - 1 : 0);
          end
          2'd1: begin
            m_k = (m_k + 1) % (2 * (N - 1));
            m_wrap = m_k == 0;
          end
          2'd2: begin
            m_blk = 1 - m_blk;
            m_wrap = m_blk == 0;
          end
          default: begin
            if (dir != m_fdir && m_lvl != 0 && m_lvl != N) m_lvl = 0;
            else m_lvl = (m_lvl + 1) % (N + 1);
            m_fdir = dir;
            m_wrap = m_lvl == 0;
          end
        endcase
      end else m_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] bnc [6];
    logic [N-1:0] fil [5];
    int hi, st;
    bnc = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    fil = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};
    tick(3);
    chk("reset led", 32'(led), 32'h0);
    chk("reset step", 32'(step_pulse), 32'h0);
    sys_rst_n = 1'b1;
    tick(1);
    chk("run start", 32'(led), 32'h1);
    tick(8); chk("run s1", 32'(led), 32'h2); chk("run s1 pulse", 32'(step_pulse), 32'h1);
    tick(8); chk("run s2", 32'(led), 32'h4);
    tick(8); chk("run s3", 32'(led), 32'h8); chk("run s3 wrap", 32'(wrap), 32'h0);
    tick(8); chk("run s4", 32'(led), 32'h1); chk("run s4 wrap", 32'(wrap), 32'h1);
    tick(7);
    mode = 2'd2;
    tick(1);
    chk("blink load", 32'(led), 32'hF);
    chk("blink load pulse", 32'(step_pulse), 32'h0);
    chk("blink load wrap", 32'(wrap), 32'h0);
    tick(8); chk("blink t1", 32'(led), 32'h0); chk("blink t1 pulse", 32'(step_pulse), 32'h1);
    tick(8); chk("blink t2", 32'(led), 32'hF); chk("blink t2 wrap", 32'(wrap), 32'h1);
    mode = 2'd1;
    tick(1);
    chk("bounce start", 32'(led), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick(8);
      chk("bounce led", 32'(led), 32'(bnc[i]));
      chk("bounce wrap", 32'(wrap), 32'(i == 5));
    end
    mode = 2'd3;
    dir = 1'b1;
    tick(1);
    chk("fill start", 32'(led), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(8);
      chk("fill led", 32'(led), 32'(fil[i]));
      chk("fill wrap", 32'(wrap), 32'(i == 4));
    end
    tick(8); tick(8);
    chk("fill pre dirchg", 32'(led), 32'hC);
    dir = 1'b0;
    tick(8);
    chk("fill dirchg led", 32'(led), 32'h0);
    chk("fill dirchg wrap", 32'(wrap), 32'h1);
    tick(8);
    chk("fill lsb s1", 32'(led), 32'h1);
    mode = 2'd0;
    tick(1);
    chk("run reload", 32'(led), 32'h1);
    tick(5);
    speed_sel = 2'd2;
    tick(1);
    chk("speed step", 32'(step_pulse), 32'h1);
    chk("speed led", 32'(led), 32'h2);
    tick(1); chk("speed gap", 32'(step_pulse), 32'h0);
    tick(1); chk("speed next", 32'(step_pulse), 32'h1); chk("speed next led", 32'(led), 32'h4);
    sys_rst_n = 1'b0;
    tick(1);
    chk("midrst led", 32'(led), 32'h0);
    chk("midrst step", 32'(step_pulse), 32'h0);
    chk("midrst wrap", 32'(wrap), 32'h0);
    sys_rst_n = 1'b1;
    speed_sel = 2'd0;
    tick(1);
    chk("rerun start", 32'(led), 32'h1);
`ifdef LED_SEQ_PWM_EN
    duty = 4'd4;
    hi = 0;
    repeat (16) begin
      tick(1);
      hi += int'(|led);
    end
    chk("pwm duty4 on-cycles", 32'(hi), 32'd4);
    duty = 4'd0;
    hi = 0;
    st = 0;
    repeat (16) begin
      tick(1);
      hi += int'(|led);
      st += int'(step_pulse);
    end
    chk("pwm duty0 on-cycles", 32'(hi), 32'd0);
    chk("pwm duty0 steps", 32'(st), 32'd2);
`else
    hi = 0;
    st = 0;
`endif
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
